// File: rtl/sdp_fifo_pkg.sv
// Shared constants and helpers for the simple-dual-port RAM FIFO controller.
package sdp_fifo_pkg;

  localparam int unsigned RD_LATENCY_MIN = 1;
  localparam int unsigned RD_LATENCY_MAX = 2;

  // Output buffer must absorb every read already in flight plus the current head.
  function automatic int unsigned buf_depth(input int unsigned rd_latency);
    return rd_latency + 1;
  endfunction

endpackage

// File: rtl/sdp_fifo_out_buf.sv
// Small register FIFO that collects RAM read data and presents the head word.
module sdp_fifo_out_buf
  import sdp_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_valid,
  output logic [LVL_W-1:0]      level
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [LVL_W-1:0]      level_q;
  logic                  pop_eff;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_eff = pop && (level_q != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_eff) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      // Simultaneous push and pop leave the level unchanged.
      case ({push, pop_eff})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: ;
      endcase
    end
  end

  assign head_data  = mem_q[rd_ptr_q];
  assign head_valid = (level_q != '0);
  assign level      = level_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop_eff && (level_q == LVL_W'(DEPTH))))
    else $error("sdp_fifo_out_buf: push into a full buffer");

endmodule

// File: rtl/sdp_fifo_ctrl.sv
// First-word-fall-through valid/ready FIFO built around an external simple-dual-port RAM.
module sdp_fifo_ctrl
  import sdp_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int unsigned BUF_DEPTH = buf_depth(RD_LATENCY);
  localparam int unsigned LVL_W     = $clog2(BUF_DEPTH + 1);
  localparam int unsigned CRD_W     = LVL_W + 1;
  localparam int unsigned RCNT_W    = ADDR_WIDTH + 1;
  localparam int unsigned CNT_W     = ADDR_WIDTH + 2;
  localparam logic [RCNT_W-1:0] RAM_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  if ((RD_LATENCY < RD_LATENCY_MIN) || (RD_LATENCY > RD_LATENCY_MAX)) begin : g_bad_latency
    $fatal(1, "sdp_fifo_ctrl: RD_LATENCY must be 1 or 2");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [RCNT_W-1:0]     ram_count_q;
  logic [RD_LATENCY-1:0] tag_q;
  logic [RD_LATENCY-1:0] tag_d;
  logic [LVL_W-1:0]      inflight;
  logic [LVL_W-1:0]      buf_level;
  logic [CRD_W-1:0]      credit_used;
  logic                  wr_fire;
  logic                  pop;
  logic                  issue;
  logic                  ret_valid;

  // Write port is a direct pass-through of the accepted producer word.
  assign in_ready    = rst_n && (ram_count_q != RAM_WORDS);
  assign wr_fire     = in_valid && in_ready;
  assign ram_wr_en   = wr_fire;
  assign ram_wr_addr = wr_ptr_q;
  assign ram_wr_data = in_data;

  // Read port free-runs so a registered RAM output stage keeps advancing.
  assign ram_rd_en   = rst_n;
  assign ram_rd_addr = rd_ptr_q;

  assign pop = out_valid && out_ready;

  // Issue only while the buffer can hold every outstanding read after this cycle's pop.
  always_comb begin
    inflight    = LVL_W'($countones(tag_q));
    credit_used = CRD_W'(inflight) + CRD_W'(buf_level) - CRD_W'(pop);
    issue       = (ram_count_q != '0) && (credit_used < CRD_W'(BUF_DEPTH));
  end

  if (RD_LATENCY == 1) begin : g_tag_l1
    assign tag_d = issue;
  end else begin : g_tag_ln
    assign tag_d = {tag_q[RD_LATENCY-2:0], issue};
  end

  assign ret_valid = tag_q[RD_LATENCY-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      tag_q       <= '0;
    end else begin
      tag_q <= tag_d;
      if (wr_fire) begin
        wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (issue) begin
        rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
      end
      case ({wr_fire, issue})
        2'b10:   ram_count_q <= ram_count_q + RCNT_W'(1);
        2'b01:   ram_count_q <= ram_count_q - RCNT_W'(1);
        default: ;
      endcase
    end
  end

  sdp_fifo_out_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH),
    .LVL_W      (LVL_W)
  ) u_out_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (ret_valid),
    .push_data  (ram_rd_data),
    .pop        (pop),
    .head_data  (out_data),
    .head_valid (out_valid),
    .level      (buf_level)
  );

  assign count = CNT_W'(ram_count_q) + CNT_W'(inflight) + CNT_W'(buf_level);

endmodule

// File: doc/sdp_fifo_ctrl.md
Name: sdp_fifo_ctrl

Overview:
- FIFO controller that drives an external simple-dual-port RAM's write and read ports and consumes its read data. It turns the RAM into a first-word-fall-through valid/ready FIFO.
- Supports RAM read latency of 1 (unregistered read data) or 2 (registered read data).
- Sits between a producer stream and a consumer stream. The RAM is instantiated beside it by the parent.

Parameters:
- DATA_WIDTH, 16, word width.
- ADDR_WIDTH, 10, RAM address width; RAM holds 2**ADDR_WIDTH words.
- RD_LATENCY, 1, RAM read latency in cycles. Legal values are 1 or 2; any other value triggers $fatal at elaboration.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  producer has a word
- in_ready  out  1  controller accepts the word (FIFO not full)
- in_data  in  DATA_WIDTH  producer word
- out_valid  out  1  head word available
- out_ready  in  1  consumer takes the head word
- out_data  out  DATA_WIDTH  head word
- count  out  ADDR_WIDTH+2  total words held (RAM + in flight + output buffer)
- ram_wr_en  out  1  RAM write enable
- ram_wr_addr  out  ADDR_WIDTH  RAM write address
- ram_wr_data  out  DATA_WIDTH  RAM write data
- ram_rd_en  out  1  RAM read enable
- ram_rd_addr  out  ADDR_WIDTH  RAM read address
- ram_rd_data  in  DATA_WIDTH  RAM read data, valid RD_LATENCY cycles after the address is sampled

Behaviour:
- Interface: clk is the single clock. rst_n is synchronous and active-low.
- Reset values: in_ready=0 while rst_n=0 and 1 after release. out_valid=0. count=0. ram_wr_en=0. wr_ptr, rd_ptr and ram_count are 0. The in-flight tag shift register and the output buffer are cleared.
- Reset mid-operation: all stored and in-flight data is discarded. RAM contents are not cleared.
- Write side:
  - in_ready = rst_n && (ram_count != 2**ADDR_WIDTH).
  - On in_valid&&in_ready: ram_wr_en=1, ram_wr_addr=wr_ptr, ram_wr_data=in_data, combinationally in the same cycle.
  - wr_ptr increments at the edge and wraps naturally at 2**ADDR_WIDTH.
  - ram_count increments at the same edge.
- Read issue:
  - ram_rd_en is held 1 whenever rst_n=1. This keeps a registered RAM output stage advancing every cycle.
  - ram_rd_addr = rd_ptr.
  - issue = (ram_count>0) && (inflight + buf_count - pop < BUF_DEPTH), where pop = out_valid&&out_ready and BUF_DEPTH = RD_LATENCY+1.
  - On issue: rd_ptr increments (wrapping), ram_count decrements, and a 1 enters the RD_LATENCY-deep tag shift register. Otherwise a 0 enters.
- Same-cycle write and issue: ram_count is unchanged.
- Read-during-write safety: issue depends only on the registered ram_count, so a read never targets the address being written in the same cycle. The controller is correct with read-first or write-first RAM.
- Return path: when the tag emerges, ram_rd_data is pushed into the output buffer at that edge. The output buffer is a BUF_DEPTH-entry register FIFO; its head drives out_data and out_valid = buf_count>0.
- Output buffer overflow is impossible by the credit rule. An overflow assertion must never fire.
- Latency: a word accepted at edge k is visible on out_valid after edge k+RD_LATENCY+1, provided the FIFO was empty.
- Throughput: with in_valid and out_ready both held high, one word per cycle is sustained in both directions.
- Simultaneous push into the output buffer and pop from it: buf_count is unchanged and order is preserved.
- Capacity: 2**ADDR_WIDTH words in RAM plus up to BUF_DEPTH in the buffer. count = ram_count + inflight + buf_count.
- out_data is stable while out_valid=1 and out_ready=0.

Decomposition:
- Package sdp_fifo_pkg:
  - function buf_depth(rd_latency) returning rd_latency+1.
  - localparam for the legal RD_LATENCY range.
- One sub-module: sdp_fifo_out_buf, a parameterized small register FIFO. Ports: push, push_data, pop, head_data, head_valid, level.
- The top level holds the pointers, ram_count, the tag shift register and the credit logic.

Test Plan:
- Reset, then in_valid=1 with in_data=0x1234 for one cycle, RD_LATENCY=1 -> ram_wr_addr=0 at cycle 0; out_valid rises after edge 2 with out_data=0x1234; count goes 1 then back to 0 after the pop.
- ADDR_WIDTH=4, RD_LATENCY=2, out_ready=0, stream 0..30 -> after 2**4+3=19 accepted words: in_ready=0, count=19, RAM pointers wrapped. Then drain and check output order 0..18.
- Continuous streaming with in_valid=out_ready=1 for 100 cycles -> one word per cycle after the pipeline fills, in-order data, count constant.
- Random in_valid/out_ready at 50% for 10k words, both latencies -> scoreboard matches exactly; no output buffer overflow; out_data stable while stalled.
- Fill 8 words, then rst_n=0 for 1 cycle mid-drain -> next cycle out_valid=0, count=0, in_ready=1 after release; the next write of 0xBEEF is the first word out.
- ram_count=1 and in_valid=1 in the same cycle as an issue -> ram_count stays 1; the RAM sees distinct rd_addr and wr_addr.
